// File: rtl/encoder_velocity.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : encoder_velocity
// Purpose  : Gated position sampler with moving-average velocity estimate.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_velocity #(
  parameter int GATE_CYCLES = 32000,
  parameter int AVG_LOG2    = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] position,
  output logic [31:0] velocity,
  output logic        velocity_valid,
  output logic [31:0] window_delta
);

  localparam int CNT_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W = 32 + AVG_LOG2;
  localparam logic [CNT_W-1:0] C_GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(DEPTH - 1);

  logic [CNT_W-1:0]        r_gate_cnt;
  logic [31:0]             r_prev_pos;
  logic                    r_s1_vld;
  logic                    r_s2_vld;
  logic [31:0]             r_buf [DEPTH];
  logic [IDX_W-1:0]        r_idx;
  logic signed [SUM_W-1:0] r_sum;

  logic                    w_tick;
  logic [31:0]             w_old;
  logic signed [SUM_W-1:0] w_sum_next;
  logic signed [SUM_W-1:0] w_avg;

  assign w_tick = (r_gate_cnt == C_GATE_LAST);

  // Entry being retired from the ring; loop form keeps depth-1 indexing in range.
  always_comb begin
    w_old = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (IDX_W'(i) == r_idx) w_old = r_buf[i];
    end
  end

  assign w_sum_next = r_sum + SUM_W'($signed(window_delta)) - SUM_W'($signed(w_old));
  assign w_avg      = r_sum >>> AVG_LOG2;

  // window_delta doubles as the S0 delta register feeding the S1 accumulate.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_gate_cnt     <= '0;
      r_prev_pos     <= position;
      r_s1_vld       <= 1'b0;
      r_s2_vld       <= 1'b0;
      r_idx          <= '0;
      r_sum          <= '0;
      velocity       <= '0;
      velocity_valid <= 1'b0;
      window_delta   <= '0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_gate_cnt <= w_tick ? '0 : r_gate_cnt + 1'b1;
      r_s1_vld   <= w_tick;
      r_s2_vld   <= r_s1_vld;

      if (w_tick) begin
        window_delta <= position - r_prev_pos;
        r_prev_pos   <= position;
      end

      if (r_s1_vld) begin
        r_sum <= w_sum_next;
        r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (IDX_W'(i) == r_idx) r_buf[i] <= window_delta;
        end
      end

      velocity_valid <= r_s2_vld;
      if (r_s2_vld) velocity <= w_avg[31:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_encoder_velocity.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_encoder_velocity
// Purpose  : Directed self-checking bench, depth-4 and depth-1 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_velocity;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] position;
  logic [31:0] vel, wd, vel0, wd0;
  logic        vv, vv0;

  int errors = 0;
  int checks = 0;
  int tc     = 0;
  bit first  = 1'b1;
  int exp_wd[$];
  int exp_vel[$];

  always #5 clk = ~clk;

  encoder_velocity #(.GATE_CYCLES(8), .AVG_LOG2(2)) dut (
    .CLK(clk), .reset(reset_n), .position(position),
    .velocity(vel), .velocity_valid(vv), .window_delta(wd)
  );

  encoder_velocity #(.GATE_CYCLES(8), .AVG_LOG2(0)) dut0 (
    .CLK(clk), .reset(reset_n), .position(position),
    .velocity(vel0), .velocity_valid(vv0), .window_delta(wd0)
  );

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One cycle: drive the rate pattern at the negedge, then inspect outputs.
  task automatic cyc(input int step, input int div);
    int ew, ev;
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_valid", 32'(vv), 0);
    end else begin
      tc++;
      if (tc % div == 0) position = position + step;
      chk("valid_sync", 32'(vv0), 32'(vv));
      if (vv) begin
        if (first) begin
          chk("first_pulse_cycle", tc, 10);
          first = 1'b0;
        end
        chk("pulse_phase", tc % 8, 2);
        if (exp_vel.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          ew = exp_wd.pop_front();
          ev = exp_vel.pop_front();
          chk("window_delta", wd, ew);
          chk("velocity", vel, ev);
          chk("velocity_avg0", vel0, ew);
        end
      end
    end
  endtask

  // Called right after a negedge; p2 is the position of the last reset cycle.
  task automatic rst_seq(input logic [31:0] p1, input logic [31:0] p2);
    chk("pending_pulses", exp_vel.size(), 0);
    exp_vel.delete();
    exp_wd.delete();
    reset_n  = 1'b0;
    position = p1;
    cyc(0, 8);
    cyc(0, 8);
    @(negedge clk);
    position = p2;
    chk("rst_velocity", vel, 0);
    chk("rst_wdelta", wd, 0);
    chk("rst_velocity0", vel0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tc      = 0;
    first   = 1'b1;
  endtask

  task automatic win(input int step, input int div, input int ewd, input int evel);
    exp_wd.push_back(ewd);
    exp_vel.push_back(evel);
    do cyc(step, div); while (tc % 8 != 7);
  endtask

  task automatic flush();
    repeat (3) cyc(0, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    position = 32'd1000;
    repeat (2) @(negedge clk);

    // Static position, then +4 per window ramping through the average.
    @(negedge clk); rst_seq(32'd1000, 32'd1000);
    win(0, 8, 0, 0); win(0, 8, 0, 0);
    win(1, 2, 4, 1); win(1, 2, 4, 2); win(1, 2, 4, 3); win(1, 2, 4, 4); win(1, 2, 4, 4);
    flush();

    // Signed counter wrap: +3 per window across 0x7FFFFFFF.
    @(negedge clk); rst_seq(32'h7FFF_FFF0, 32'h7FFF_FFFE);
    win(0, 8, 0, 0);
    win(3, 8, 3, 0); win(3, 8, 3, 1); win(3, 8, 3, 2); win(3, 8, 3, 3); win(3, 8, 3, 3);
    flush();

    // Negative delta, floor rounding.
    @(negedge clk); rst_seq(32'd100, 32'd100);
    win(0, 8, 0, 0);
    win(-5, 8, -5, -2); win(-5, 8, -5, -3); win(-5, 8, -5, -4); win(-5, 8, -5, -5); win(-5, 8, -5, -5);
    flush();

    // Direction reversal.
    @(negedge clk); rst_seq(32'd0, 32'd0);
    win(0, 8, 0, 0);
    win(8, 8, 8, 2); win(8, 8, 8, 4); win(8, 8, 8, 6); win(8, 8, 8, 8);
    win(-8, 8, -8, 4); win(-8, 8, -8, 0); win(-8, 8, -8, -4); win(-8, 8, -8, -8);
    flush();

    // Reset in the cycle after a tick: that window's pulse must never appear.
    @(negedge clk); rst_seq(32'd2000, 32'd2000);
    win(0, 8, 0, 0); win(4, 8, 4, 1); win(4, 8, 4, 2);
    do cyc(4, 8); while (tc % 8 != 7);
    @(negedge clk);
    chk("mid_wdelta", wd, 4);
    rst_seq(32'd3000, 32'd5000);
    win(0, 8, 0, 0); win(4, 8, 4, 1); win(4, 8, 4, 2);
    flush();
    chk("final_pending", exp_vel.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
